// File: rtl/comb_resp_checker.sv
// Checks four implementations of a 4-input boolean function against a truth table
// over a 16-vector run, counting per-implementation mismatches and sequence errors.
module comb_resp_checker #(
  parameter logic [15:0] TRUTH = 16'h6996
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        vec_valid,
  input  logic [3:0]  vec,
  input  logic [3:0]  res,
  output logic        vec_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [19:0] impl_err,
  output logic [3:0]  first_err_vec,
  output logic [3:0]  first_err_res
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [4:0]  r_err_cnt;
  logic [19:0] r_impl_err;
  logic [3:0]  r_first_vec;
  logic [3:0]  r_first_res;

  logic        w_accept;
  logic        w_exp;
  logic [3:0]  w_mis;
  logic        w_err;

  function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic en);
    return (en && (v != 5'd31)) ? v + 5'd1 : v;
  endfunction

  assign w_accept = vec_valid && (r_state == S_RUN);
  assign w_exp    = TRUTH[vec];
  assign w_mis    = res ^ {4{w_exp}};
  assign w_err    = (|w_mis) || (vec != r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_err_cnt   <= 5'd0;
      r_impl_err  <= 20'd0;
      r_first_vec <= 4'd0;
      r_first_res <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_idx       <= 4'd0;
            r_err_cnt   <= 5'd0;
            r_impl_err  <= 20'd0;
            r_first_vec <= 4'd0;
            r_first_res <= 4'd0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_idx <= r_idx + 4'd1;
            for (int k = 0; k < 4; k++) begin
              r_impl_err[k*5 +: 5] <= sat_inc(r_impl_err[k*5 +: 5], w_mis[k]);
            end
            r_err_cnt <= sat_inc(r_err_cnt, w_err);
            // err_cnt only saturates, never wraps, so zero means no error seen yet
            if (w_err && (r_err_cnt == 5'd0)) begin
              r_first_vec <= vec;
              r_first_res <= res;
            end
            if (r_idx == 4'd15) begin
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_ready     = (r_state == S_RUN);
  assign busy          = (r_state == S_RUN);
  assign done          = (r_state == S_DONE);
  assign pass          = (r_state == S_DONE) && (r_err_cnt == 5'd0);
  assign err_cnt       = r_err_cnt;
  assign impl_err      = r_impl_err;
  assign first_err_vec = r_first_vec;
  assign first_err_res = r_first_res;

endmodule

// File: tb/tb_comb_resp_checker.sv
// Randomized bench for comb_resp_checker; expected run results are computed from
// the recorded vector/response list of each run.
module tb_comb_resp_checker;

  localparam logic [15:0] TRUTH = 16'h6996;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        vec_valid = 1'b0;
  logic [3:0]  vec = 4'd0;
  logic [3:0]  res = 4'd0;
  logic        vec_ready, busy, done, pass;
  logic [4:0]  err_cnt;
  logic [19:0] impl_err;
  logic [3:0]  first_err_vec, first_err_res;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] g_vec [16];
  logic [3:0] g_res [16];

  comb_resp_checker #(.TRUTH(TRUTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec(vec), .res(res), .vec_ready(vec_ready), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .impl_err(impl_err),
    .first_err_vec(first_err_vec), .first_err_res(first_err_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] good_res(input logic [3:0] v);
    return {4{TRUTH[v]}};
  endfunction

  task automatic fill_clean();
    for (int i = 0; i < 16; i++) begin
      g_vec[i] = 4'(i);
      g_res[i] = good_res(4'(i));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, 32'(vec_ready), 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".done"},  32'(done), 32'd0);
    chk({tag, ".pass"},  32'(pass), 32'd0);
    chk({tag, ".err"},   32'(err_cnt), 32'd0);
    chk({tag, ".impl"},  32'(impl_err), 32'd0);
    chk({tag, ".fvec"},  32'(first_err_vec), 32'd0);
    chk({tag, ".fres"},  32'(first_err_res), 32'd0);
  endtask

  // gap_mode: 0 back-to-back, 1 alternate gap/valid, 2 random gaps
  task automatic run(input string tag, input int gap_mode, input bit start_noise);
    int n, cyc, e;
    int ic [4];
    logic [3:0] fv, fr, mis;
    logic [31:0] eimpl;
    bit v;
    e = 0; fv = 4'd0; fr = 4'd0;
    ic = '{0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      mis = g_res[i] ^ good_res(g_vec[i]);
      for (int k = 0; k < 4; k++) if (mis[k]) ic[k]++;
      if (mis != 4'd0 || g_vec[i] != 4'(i)) begin
        if (e == 0) begin fv = g_vec[i]; fr = g_res[i]; end
        e++;
      end
    end
    if (e > 31) e = 31;
    eimpl = 32'd0;
    for (int k = 0; k < 4; k++) eimpl |= 32'(ic[k] > 31 ? 31 : ic[k]) << (5 * k);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".start_busy"}, 32'(busy), 32'd1);
    chk({tag, ".start_err"},  32'(err_cnt), 32'd0);
    chk({tag, ".start_impl"}, 32'(impl_err), 32'd0);
    chk({tag, ".start_fvec"}, 32'(first_err_vec), 32'd0);

    n = 0; cyc = 0;
    while (n < 16 && cyc < 400) begin
      case (gap_mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 1;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      vec_valid = v;
      vec = v ? g_vec[n] : 4'($urandom);
      res = v ? g_res[n] : 4'($urandom);
      if (start_noise) start = ($urandom_range(0, 3) == 0);
      chk({tag, ".run_ready"}, 32'(vec_ready), 32'd1);
      tick();
      if (v) n++;
      cyc++;
    end
    vec_valid = 1'b0;
    start = 1'b0;
    chk({tag, ".accepts"}, 32'(n), 32'd16);
    if (gap_mode == 0) chk({tag, ".cycles"}, 32'(cyc), 32'd16);
    if (gap_mode == 1) chk({tag, ".cycles"}, 32'(cyc), 32'd32);
    chk({tag, ".done"},  32'(done), 32'd1);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".ready"}, 32'(vec_ready), 32'd0);
    chk({tag, ".pass"},  32'(pass), 32'(e == 0));
    chk({tag, ".err"},   32'(err_cnt), 32'(e));
    chk({tag, ".impl"},  32'(impl_err), eimpl);
    chk({tag, ".fvec"},  32'(first_err_vec), 32'(fv));
    chk({tag, ".fres"},  32'(first_err_res), 32'(fr));

    vec_valid = 1'b1;
    vec = 4'($urandom);
    res = ~good_res(vec);
    tick();
    vec_valid = 1'b0;
    chk({tag, ".hold_done"}, 32'(done), 32'd1);
    chk({tag, ".hold_err"},  32'(err_cnt), 32'(e));
    chk({tag, ".hold_impl"}, 32'(impl_err), eimpl);
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    vec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vec = 4'($urandom);
      res = 4'($urandom);
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
    end
    chk("idle_ready", 32'(vec_ready), 32'd0);
    vec_valid = 1'b0;

    fill_clean();
    run("clean", 0, 1'b0);

    fill_clean();
    g_res[5] = g_res[5] ^ 4'b0010;
    run("fault", 0, 1'b0);

    fill_clean();
    g_vec[2] = 4'd3;
    g_res[2] = good_res(4'd3);
    run("seq", 0, 1'b0);

    fill_clean();
    run("gap", 1, 1'b1);

    fill_clean();
    g_res[2] = ~g_res[2];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      vec_valid = 1'b1;
      vec = g_vec[i];
      res = g_res[i];
      tick();
    end
    chk("prerst_err", 32'(err_cnt), 32'd1);
    chk("prerst_fvec", 32'(first_err_vec), 32'd2);
    vec = g_vec[7];
    res = g_res[7];
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vec = 4'($urandom);
      tick();
    end
    vec_valid = 1'b0;
    chk_all_zero("post_rst");

    fill_clean();
    for (int i = 0; i < 16; i++) g_res[i] = ~good_res(4'(i));
    run("inv1", 0, 1'b0);
    run("inv2", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        g_vec[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(i);
        g_res[i] = good_res(g_vec[i]) ^ (($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0);
      end
      run("rand", 2, r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/comb_resp_checker.md
COMB_RESP_CHECKER -- requirements
Module: comb_resp_checker

Interface
REQ-001 Parameter TRUTH, default 16'h6996, expected single-bit output of the checked function; bit i is the expected value for input DCBA = i.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a 16-vector check run.
REQ-005 vec_valid  input  1  the stimulus side presents a vector and its responses this cycle.
REQ-006 vec  input  4  applied input vector, {D,C,B,A}.
REQ-007 res  input  4  implementation responses, {prim, behavior, dataflow, str}.
REQ-008 vec_ready  output  1  checker accepts a vector this cycle.
REQ-009 busy  output  1  run in progress.
REQ-010 done  output  1  run complete; held until the next start or reset.
REQ-011 pass  output  1  valid while done; 1 when the run had zero erroneous vectors.
REQ-012 err_cnt  output  5  number of erroneous vectors in the current or last run.
REQ-013 impl_err  output  20  per-implementation mismatch counters, 5 bits each: [4:0] str, [9:5] dataflow, [14:10] behavior, [19:15] prim.
REQ-014 first_err_vec  output  4  vec of the first erroneous vector in the run.
REQ-015 first_err_res  output  4  res of the first erroneous vector in the run.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE: start -> RUN; otherwise remain.
REQ-018 RUN: remain until the vector with index 15 is accepted, then -> DONE on the next edge.
REQ-019 DONE: start -> RUN; otherwise remain.
REQ-020 start in RUN SHALL be ignored.
REQ-021 On the start edge, the block SHALL clear err_cnt, impl_err, first_err_vec, first_err_res and the expected-index counter (4 bits) to 0.
REQ-022 vec_ready = 1 exactly when the state is RUN (combinational decode of the state register).
REQ-023 busy = (state == RUN); done = (state == DONE).
REQ-024 A vector is accepted on an edge where vec_valid && vec_ready.
REQ-025 vec_valid outside RUN SHALL have no effect.
REQ-026 Per accepted vector, bit k of res mismatches when res[k] != TRUTH[vec].
REQ-027 Each mismatching bit k SHALL increment its impl_err field by 1, saturating at 31.
REQ-028 The accepted vector is erroneous when any res bit mismatches, or when vec != the expected index (sequence error).
REQ-029 Each erroneous vector SHALL increment err_cnt by 1, saturating at 31.
REQ-030 On the first erroneous vector of a run only, first_err_vec and first_err_res SHALL capture vec and res; later errors leave them unchanged.
REQ-031 The expected index SHALL increment by 1 per accepted vector, regardless of error.
REQ-032 Run completion SHALL be determined by the expected index reaching 15 on acceptance, not by the value of vec.
REQ-033 All counters and capture registers SHALL update on the same edge that accepts the vector (one-cycle latency from acceptance to visible outputs).
REQ-034 pass = done && (err_cnt == 0); pass SHALL be 0 outside DONE.
REQ-035 Gaps of any length (vec_valid low) during RUN SHALL pause the run without error.

Reset
REQ-036 While rst_n is low, the block SHALL asynchronously force: state IDLE; the expected index, err_cnt, impl_err, first_err_vec and first_err_res to 0.
REQ-037 Consequently, during reset vec_ready, busy, done and pass SHALL be 0.
REQ-038 Reset asserted mid-run SHALL abort the run; after release the block SHALL stay in IDLE until start.
REQ-039 Release of rst_n SHALL be sampled synchronously; the first state change occurs no earlier than the first edge after release.

Verification
REQ-040 Clean run: start, then vec = 0..15 back-to-back with res = {4{TRUTH[vec]}} -> busy for 16 cycles; done = 1, pass = 1, err_cnt = 0, impl_err = 0.
REQ-041 Single fault: as REQ-040, but res[1] inverted at vec = 5 -> err_cnt = 1, impl_err[9:5] = 1, other fields 0, first_err_vec = 4'd5, first_err_res = 4'b0010, pass = 0.
REQ-042 Sequence error: vec = 3 presented at index 2 with correct responses -> err_cnt = 1, impl_err = 0, first_err_vec = 4'd3; run still ends after 16 accepts.
REQ-043 Gapped stimulus: vec_valid toggled 1/0 each cycle -> done after 32 cycles, pass = 1; start pulsed mid-run -> no effect.
REQ-044 Reset mid-run: rst_n low after 7 accepts -> all outputs 0 immediately (asynchronous); after release, outputs stay 0 and state IDLE until start.
REQ-045 Saturation and restart: TRUTH inverted relative to the responses for two back-to-back runs -> per run err_cnt = 16 and each impl_err field = 16; start from DONE clears all counters before the second run.
